// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the writeback arbiter slice.
//   DATA_W / ADDR_W : register-file data and address widths
//   NUM_REGS        : number of architectural registers (width of pend_mask)
//   wb_entry_t      : one pending register write {addr, data}
//   REG_ZERO        : hard-wired zero register; writes to it are dropped
//   grant_e         : which source owns the write port in a given cycle
//   reg_onehot()    : one-hot decode of a register address
// ----------------------------------------------------------------------------
package wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_FIFO = 2'd2
    } grant_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// wb_write_arbiter_if
// Bundles the MEM/WB input stream, the long-latency unit handshake and the
// register-file write port plus hazard outputs of the writeback arbiter.
//   slave  : arbiter side (consumes pipe_*/lu_*, drives write/wr/wd,
//            lu_ready, stall_req, pend_mask)
//   master : environment side (pipeline, long-latency unit, register file)
// ----------------------------------------------------------------------------
interface wb_write_arbiter_if;
    import wb_pkg::*;

    logic                pipe_valid;
    logic [ADDR_W-1:0]   pipe_wr;
    logic [DATA_W-1:0]   pipe_wd;
    logic                lu_valid;
    logic                lu_ready;
    logic [ADDR_W-1:0]   lu_wr;
    logic [DATA_W-1:0]   lu_wd;
    logic                write;
    logic [ADDR_W-1:0]   wr;
    logic [DATA_W-1:0]   wd;
    logic                stall_req;
    logic [NUM_REGS-1:0] pend_mask;

    modport slave (
        input  pipe_valid, pipe_wr, pipe_wd,
        input  lu_valid, lu_wr, lu_wd,
        output lu_ready,
        output write, wr, wd,
        output stall_req, pend_mask
    );

    modport master (
        output pipe_valid, pipe_wr, pipe_wd,
        output lu_valid, lu_wr, lu_wd,
        input  lu_ready,
        input  write, wr, wd,
        input  stall_req, pend_mask
    );

endinterface

// File: rtl/wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO of pending long-latency register writes.
//   clk, reset     : clock, asynchronous active-high reset (empties FIFO)
//   i_push         : write i_push_data at the tail (caller guarantees not full)
//   i_pop          : drop the head entry (caller guarantees not empty)
//   o_head         : current head entry (valid when o_count != 0)
//   o_count        : number of valid entries, 0..DEPTH
//   o_entry_valid  : per-slot valid flag, used to build the pending mask
//   o_entry_addr   : per-slot destination register
// The head is read combinationally so a pop can be granted in the same cycle
// the head becomes visible; the storage is a handful of registers.
// ----------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_push,
    input  wb_entry_t                         i_push_data,
    input  logic                              i_pop,
    output wb_entry_t                         o_head,
    output logic [$clog2(DEPTH):0]            o_count,
    output logic [DEPTH-1:0]                  o_entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]      o_entry_addr
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset: validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // A slot is live when its distance from the read pointer (modulo DEPTH,
    // which is a power of two) is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [PTR_W-1:0] w_offset;
        assign w_offset           = PTR_W'(gi) - r_rd_ptr;
        assign o_entry_valid[gi]  = ({1'b0, w_offset} < r_count);
        assign o_entry_addr[gi]   = r_mem[gi].addr;
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// ----------------------------------------------------------------------------
// wb_write_arbiter
// Drives the single register-file write port, merging the in-order MEM/WB
// stream with buffered long-latency (mul/div) results.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : wb_write_arbiter_if.slave
//       pipe_valid/pipe_wr/pipe_wd : MEM/WB result (held stable by upstream)
//       lu_valid/lu_ready/lu_wr/lu_wd : long-latency result handshake
//       write/wr/wd  : registered register-file write port
//       stall_req    : asks the pipeline to hold MEM/WB so the FIFO head drains
//       pend_mask    : registers with a write still waiting in the FIFO
// Priority: starving FIFO head > qualified pipe result > FIFO head > none.
// ----------------------------------------------------------------------------
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    wb_write_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t                        w_head;
    wb_entry_t                        w_push_data;
    logic [CNT_W-1:0]                 w_count;
    logic [FIFO_DEPTH-1:0]            w_entry_valid;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] w_entry_addr;
    logic                             w_empty;
    logic                             w_lu_ready;
    logic                             w_push;
    logic                             w_pop;
    logic                             w_pipe_q;
    logic                             w_stall;
    grant_e                           w_grant;
    logic [NUM_REGS-1:0]              w_dec [FIFO_DEPTH];
    logic [NUM_REGS-1:0]              w_pend;

    logic [AGE_W-1:0]                 r_age;
    logic                             r_write;
    logic [ADDR_W-1:0]                r_wr;
    logic [DATA_W-1:0]                r_wd;

    // lu_ready looks only at the registered occupancy, so a pop in the same
    // cycle never lets a full FIFO accept.
    assign w_empty     = (w_count == '0);
    assign w_lu_ready  = (w_count < CNT_W'(FIFO_DEPTH));
    // Results targeting the zero register complete the handshake but vanish.
    assign w_push      = bus.lu_valid && w_lu_ready && (bus.lu_wr != REG_ZERO);
    assign w_push_data = '{addr: bus.lu_wr, data: bus.lu_wd};
    assign w_pipe_q    = bus.pipe_valid && (bus.pipe_wr != REG_ZERO);
    assign w_stall     = (r_age == AGE_W'(STARVE_LIMIT)) && !w_empty;

    always_comb begin
        w_grant = GNT_NONE;
        if (w_stall) begin
            w_grant = GNT_FIFO;
        end else if (w_pipe_q) begin
            w_grant = GNT_PIPE;
        end else if (!w_empty) begin
            w_grant = GNT_FIFO;
        end
    end

    assign w_pop = (w_grant == GNT_FIFO);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_push),
        .i_push_data   (w_push_data),
        .i_pop         (w_pop),
        .o_head        (w_head),
        .o_count       (w_count),
        .o_entry_valid (w_entry_valid),
        .o_entry_addr  (w_entry_addr)
    );

    // Age of the current head: counts cycles it has been passed over and
    // saturates, so stall_req stays up until the head is finally written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_age <= '0;
        end else if (w_empty || w_pop) begin
            r_age <= '0;
        end else if (r_age < AGE_W'(STARVE_LIMIT)) begin
            r_age <= r_age + 1'b1;
        end
    end

    // Write port: wr/wd keep their last value on idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write <= 1'b0;
            r_wr    <= '0;
            r_wd    <= '0;
        end else begin
            case (w_grant)
                GNT_PIPE: begin
                    r_write <= 1'b1;
                    r_wr    <= bus.pipe_wr;
                    r_wd    <= bus.pipe_wd;
                end
                GNT_FIFO: begin
                    r_write <= 1'b1;
                    r_wr    <= w_head.addr;
                    r_wd    <= w_head.data;
                end
                default: begin
                    r_write <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_dec
        assign w_dec[gi] = w_entry_valid[gi] ? reg_onehot(w_entry_addr[gi]) : '0;
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_pend = w_pend | w_dec[i];
        end
    end

    assign bus.lu_ready  = w_lu_ready;
    assign bus.write     = r_write;
    assign bus.wr        = r_wr;
    assign bus.wd        = r_wd;
    assign bus.stall_req = w_stall;
    assign bus.pend_mask = w_pend;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_write_arbiter
// Directed scenarios followed by a randomized run, every cycle compared
// against a queue-based reference model of the writeback rules.
// ----------------------------------------------------------------------------
module tb_wb_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clk;
    logic reset;

    wb_write_arbiter_if bus_if ();

    wb_write_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    ent_t        mq[$];
    int          m_age;
    logic        m_write;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    int n_vec;
    int n_err;
    int cyc;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_age   = 0;
        m_write = 1'b0;
        m_wr    = '0;
        m_wd    = '0;
    endtask

    task automatic check_all(input string t);
        logic [31:0] pm;
        pm = '0;
        foreach (mq[i]) pm[mq[i].a] = 1'b1;
        chk({t, "_write"},    bus_if.write,     m_write);
        chk({t, "_wr"},       bus_if.wr,        m_wr);
        chk({t, "_wd"},       bus_if.wd,        m_wd);
        chk({t, "_stall"},    bus_if.stall_req, (m_age == LIMIT) && (mq.size() != 0));
        chk({t, "_lu_ready"}, bus_if.lu_ready,  mq.size() < DEPTH);
        chk({t, "_pend"},     bus_if.pend_mask, pm);
    endtask

    // One clock: check current outputs, apply inputs, advance model and DUT.
    task automatic cycle(input logic pv, input logic [4:0] pwr, input logic [31:0] pwd,
                         input logic lv, input logic [4:0] lwr, input logic [31:0] lwd);
        bit ready, stall, q, popped, was_empty;
        check_all($sformatf("c%0d", cyc));
        bus_if.pipe_valid = pv;
        bus_if.pipe_wr    = pwr;
        bus_if.pipe_wd    = pwd;
        bus_if.lu_valid   = lv;
        bus_if.lu_wr      = lwr;
        bus_if.lu_wd      = lwd;

        ready     = mq.size() < DEPTH;
        was_empty = mq.size() == 0;
        stall     = (m_age == LIMIT) && !was_empty;
        q         = pv && (pwr != 0);
        popped    = 1'b0;
        if (stall || (!q && !was_empty)) begin
            m_write = 1'b1;
            m_wr    = mq[0].a;
            m_wd    = mq[0].d;
            void'(mq.pop_front());
            popped  = 1'b1;
        end else if (q) begin
            m_write = 1'b1;
            m_wr    = pwr;
            m_wd    = pwd;
        end else begin
            m_write = 1'b0;
        end
        if (was_empty || popped) m_age = 0;
        else if (m_age < LIMIT)  m_age = m_age + 1;
        if (lv && ready && (lwr != 0)) mq.push_back('{a: lwr, d: lwd});

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        int k;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        reset = 1'b1;
        bus_if.pipe_valid = 1'b0;
        bus_if.pipe_wr    = '0;
        bus_if.pipe_wd    = '0;
        bus_if.lu_valid   = 1'b0;
        bus_if.lu_wr      = '0;
        bus_if.lu_wd      = '0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset then idle
        chk("rst_write",    bus_if.write,     1'b0);
        chk("rst_wr",       bus_if.wr,        5'd0);
        chk("rst_wd",       bus_if.wd,        32'd0);
        chk("rst_stall",    bus_if.stall_req, 1'b0);
        chk("rst_pend",     bus_if.pend_mask, 32'd0);
        chk("rst_lu_ready", bus_if.lu_ready,  1'b1);
        idle();
        idle();

        // Pipe write to r5, then pipe write to r0 (dropped)
        cycle(1'b1, 5'd5, 32'h1010_1010, 1'b0, 5'd0, 32'd0);
        chk("pipe5_write", bus_if.write, 1'b1);
        chk("pipe5_wr",    bus_if.wr,    5'd5);
        chk("pipe5_wd",    bus_if.wd,    32'h1010_1010);
        cycle(1'b1, 5'd0, 32'h1010_1010, 1'b0, 5'd0, 32'd0);
        chk("pipe0_write", bus_if.write, 1'b0);
        idle();

        // LU push r7 with pipe idle
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        chk("lu7_pend_set", bus_if.pend_mask, 32'h0000_0080);
        idle();
        chk("lu7_write", bus_if.write, 1'b1);
        chk("lu7_wr",    bus_if.wr,    5'd7);
        chk("lu7_wd",    bus_if.wd,    32'hDEAD_BEEF);
        chk("lu7_pend_clr", bus_if.pend_mask, 32'd0);
        idle();

        // Pipe busy every cycle; r8 and r9 pushed back to back
        cycle(1'b1, 5'd20, $urandom, 1'b1, 5'd8, 32'h8888_0008);
        k = 1;
        cycle(1'b1, 5'd21, $urandom, 1'b1, 5'd9, 32'h9999_0009);
        k = 2;
        chk("full_lu_ready", bus_if.lu_ready, 1'b0);
        while (!(bus_if.write && bus_if.wr == 5'd8) && k < 20) begin
            cycle(1'b1, 5'(20 + k % 5), $urandom, 1'b0, 5'd0, 32'd0);
            k++;
        end
        chk("r8_latency", k, LIMIT + 2);
        k = 0;
        while (!(bus_if.write && bus_if.wr == 5'd9) && k < 20) begin
            cycle(1'b1, 5'(20 + k % 5), $urandom, 1'b0, 5'd0, 32'd0);
            k++;
        end
        chk("r9_gap", k, LIMIT + 1);
        chk("r9_wd", bus_if.wd, 32'h9999_0009);
        idle();
        idle();

        // Push and pop together on a one-entry FIFO
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB);
        chk("pp_wr10",    bus_if.wr,        5'd10);
        chk("pp_pend",    bus_if.pend_mask, 32'h0000_0800);
        chk("pp_lu_ready", bus_if.lu_ready, 1'b1);
        idle();
        chk("pp_wr11", bus_if.wr, 5'd11);
        idle();

        // Reset while FIFO holds two entries and a write is in flight
        cycle(1'b1, 5'd3, 32'h3, 1'b1, 5'd12, 32'hC);
        cycle(1'b1, 5'd3, 32'h4, 1'b1, 5'd13, 32'hD);
        check_all("pre_rst");
        chk("pre_rst_write", bus_if.write, 1'b1);
        chk("pre_rst_full",  bus_if.lu_ready, 1'b0);
        bus_if.lu_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_write",    bus_if.write,     1'b0);
        chk("mid_rst_pend",     bus_if.pend_mask, 32'd0);
        chk("mid_rst_lu_ready", bus_if.lu_ready,  1'b1);
        chk("mid_rst_stall",    bus_if.stall_req, 1'b0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 1) != 0, 5'($urandom_range(0, 31)), $urandom);
        end
        for (int i = 0; i < 8; i++) idle();
        check_all("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
